// File: rtl/ext_pkg.sv
// ---------------------------------------------------------------------------
// ext_pkg
// Shared definitions for the extension pipeline:
//   - default datapath / immediate widths
//   - in_op extension-mode encodings
// No ports; imported by ext_core and ext_pipe.
// ---------------------------------------------------------------------------
package ext_pkg;

    localparam int EXT_DATA_W_DEF = 32;
    localparam int EXT_IMM_W_DEF  = 16;

    typedef enum logic [2:0] {
        OP_ZEXT = 3'b000,   // zero-extend immediate
        OP_LUI  = 3'b001,   // immediate in the upper bits, low bits zero
        OP_SEXT = 3'b010,   // sign-extend immediate
        OP_PASS = 3'b011,   // pass the whole word through
        OP_LB   = 3'b100,   // signed byte load
        OP_LBU  = 3'b101,   // unsigned byte load
        OP_LH   = 3'b110,   // signed halfword load
        OP_LHU  = 3'b111    // unsigned halfword load
    } ext_op_e;

endpackage

// File: rtl/ext_core.sv
// ---------------------------------------------------------------------------
// ext_core
// Purely combinational extension unit.
// Ports:
//   in_data [DATA_W] : immediate (low IMM_W bits) or raw memory word
//   in_off  [2]      : byte offset inside the 32-bit word (load modes only)
//   in_op   [3]      : extension mode (ext_pkg::ext_op_e)
//   data    [DATA_W] : extended result
//   err     [1]      : misaligned halfword access
// ---------------------------------------------------------------------------
module ext_core
    import ext_pkg::*;
#(
    parameter int DATA_W = EXT_DATA_W_DEF,
    parameter int IMM_W  = EXT_IMM_W_DEF
) (
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_off,
    input  logic [2:0]        in_op,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    logic [IMM_W-1:0] imm_s;
    logic [7:0]       byte_s;
    logic [15:0]      half_s;

    assign imm_s = in_data[IMM_W-1:0];

    // Select the addressed byte and halfword of the low 32-bit word.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (in_off)
            2'd0:    byte_s = in_data[7:0];
            2'd1:    byte_s = in_data[15:8];
            2'd2:    byte_s = in_data[23:16];
            2'd3:    byte_s = in_data[31:24];
            default: byte_s = 8'h00;
        endcase
        if (in_off[1]) begin
            half_s = in_data[31:16];
        end else begin
            half_s = in_data[15:0];
        end
    end

    // Apply the requested extension; misaligned halfwords yield zero plus err.
    always_comb begin
        data = '0;
        err  = 1'b0;
        case (ext_op_e'(in_op))
            OP_ZEXT: data = {{(DATA_W-IMM_W){1'b0}}, imm_s};
            OP_LUI:  data = {imm_s, {(DATA_W-IMM_W){1'b0}}};
            OP_SEXT: data = {{(DATA_W-IMM_W){imm_s[IMM_W-1]}}, imm_s};
            OP_PASS: data = in_data;
            OP_LB:   data = {{(DATA_W-8){byte_s[7]}}, byte_s};
            OP_LBU:  data = {{(DATA_W-8){1'b0}}, byte_s};
            OP_LH, OP_LHU: begin
                if (in_off[0]) begin
                    data = '0;
                    err  = 1'b1;
                end else if (ext_op_e'(in_op) == OP_LH) begin
                    data = {{(DATA_W-16){half_s[15]}}, half_s};
                end else begin
                    data = {{(DATA_W-16){1'b0}}, half_s};
                end
            end
            default: begin
                data = '0;
                err  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// ---------------------------------------------------------------------------
// ext_pipe
// Extension unit followed by a 2-entry skid buffer (main + skid) giving a
// 1-cycle latency, full-throughput valid/ready pipeline stage.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream handshake (in_ready registered)
//   in_data, in_off, in_op : beat payload, see ext_core
//   flush               : discard all buffered beats (wins over transfers)
//   out_valid/out_ready : downstream handshake
//   out_data, out_err   : registered result, held stable while stalled
// ---------------------------------------------------------------------------
module ext_pipe
    import ext_pkg::*;
#(
    parameter int DATA_W = EXT_DATA_W_DEF,
    parameter int IMM_W  = EXT_IMM_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_off,
    input  logic [2:0]        in_op,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    logic [DATA_W-1:0] core_data_s;
    logic              core_err_s;

    logic              main_valid_r, main_valid_nxt_s;
    logic [DATA_W-1:0] main_data_r,  main_data_nxt_s;
    logic              main_err_r,   main_err_nxt_s;
    logic              skid_valid_r, skid_valid_nxt_s;
    logic [DATA_W-1:0] skid_data_r,  skid_data_nxt_s;
    logic              skid_err_r,   skid_err_nxt_s;
    logic              in_ready_r;

    logic              in_fire_s;
    logic              out_fire_s;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_core (
        .in_data (in_data),
        .in_off  (in_off),
        .in_op   (in_op),
        .data    (core_data_s),
        .err     (core_err_s)
    );

    assign in_fire_s  = in_valid && in_ready_r;
    assign out_fire_s = main_valid_r && out_ready;

    // Skid-buffer next state; the skid is only ever filled while main is full.
    always_comb begin
        main_valid_nxt_s = main_valid_r;
        main_data_nxt_s  = main_data_r;
        main_err_nxt_s   = main_err_r;
        skid_valid_nxt_s = skid_valid_r;
        skid_data_nxt_s  = skid_data_r;
        skid_err_nxt_s   = skid_err_r;
        if (flush) begin
            main_valid_nxt_s = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (skid_valid_r) begin
            // in_ready is low here, so only the output side can move.
            if (out_fire_s) begin
                main_data_nxt_s  = skid_data_r;
                main_err_nxt_s   = skid_err_r;
                skid_valid_nxt_s = 1'b0;
            end else begin
                skid_valid_nxt_s = 1'b1;
            end
        end else if (in_fire_s) begin
            if (main_valid_r && !out_fire_s) begin
                // Output stalled: park the new beat behind main.
                skid_valid_nxt_s = 1'b1;
                skid_data_nxt_s  = core_data_s;
                skid_err_nxt_s   = core_err_s;
            end else begin
                main_valid_nxt_s = 1'b1;
                main_data_nxt_s  = core_data_s;
                main_err_nxt_s   = core_err_s;
            end
        end else if (out_fire_s) begin
            main_valid_nxt_s = 1'b0;
        end else begin
            main_valid_nxt_s = main_valid_r;
        end
    end

    // Pipeline state registers; in_ready tracks the next-cycle skid state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_r <= 1'b0;
            main_data_r  <= '0;
            main_err_r   <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
            skid_err_r   <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            main_valid_r <= main_valid_nxt_s;
            main_data_r  <= main_data_nxt_s;
            main_err_r   <= main_err_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            skid_data_r  <= skid_data_nxt_s;
            skid_err_r   <= skid_err_nxt_s;
            in_ready_r   <= !skid_valid_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;
    assign out_err   = main_err_r;

endmodule
